// File: rtl/cpumc_arb.sv
// cpumc_arb: owner arbiter for the shared CPU memory bus.
// Requesters by priority: debugger, DMC sample fetch, sprite DMA, CPU.
// The CPU is stalled via cpu_ready_out. The bus is handed over only through
// a parked read of PARK_ADDR (HALT before a grant, REL after it).
// Optional stall counter: define CPUMC_ARB_STATS_EN to add stall_cnt_out/stall_clr_in.
module cpumc_arb #(
  parameter logic [15:0] PARK_ADDR = 16'h0000,
  parameter int unsigned DMC_LAT   = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_ready_out,
  input  logic        dbg_req_in,
  input  logic [15:0] dbg_a_in,
  input  logic        dbg_r_nw_in,
  input  logic [7:0]  dbg_d_in,
  output logic        dbg_gnt_out,
  input  logic        dmc_req_in,
  input  logic [15:0] dmc_a_in,
  output logic        dmc_gnt_out,
  output logic        dmc_ack_out,
  output logic [7:0]  dmc_d_out,
  input  logic        dma_req_in,
  input  logic        dma_lock_in,
  input  logic [15:0] dma_a_in,
  input  logic        dma_r_nw_in,
  input  logic [7:0]  dma_d_in,
  output logic        dma_gnt_out,
  input  logic [7:0]  cpumc_din_in,
  output logic [15:0] cpumc_a_out,
  output logic        cpumc_r_nw_out,
  output logic [7:0]  cpumc_d_out
`ifdef CPUMC_ARB_STATS_EN
  ,
  input  logic        stall_clr_in,
  output logic [15:0] stall_cnt_out
`endif
);

  typedef enum logic [2:0] {
    ST_CPU,
    ST_HALT,
    ST_DBG,
    ST_DMC,
    ST_DMCW,
    ST_DMA,
    ST_REL
  } state_e;

  // Last DMC cycle index (DMC cycle is index 0) at which read data is valid.
  localparam logic [7:0] LAT_LAST = 8'(DMC_LAT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        dbg_gnt_q, dbg_gnt_d;
  logic        dmc_gnt_q, dmc_gnt_d;
  logic        dma_gnt_q, dma_gnt_d;
  logic        dmc_ack_q, dmc_ack_d;
  logic [7:0]  dmc_d_q, dmc_d_d;
  logic        any_req;
  logic        capture;
  logic        dmcw_done;

  assign any_req = dbg_req_in | dmc_req_in | dma_req_in;

  // Next owner, DMC wait count and read-byte capture.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    capture   = 1'b0;
    dmcw_done = (DMC_LAT <= 2) || (wait_q == LAT_LAST);
    unique case (state_q)
      ST_CPU: begin
        // A CPU write cycle is never interrupted.
        if (any_req && cpu_r_nw_in) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (dbg_req_in)      state_d = ST_DBG;
        else if (dmc_req_in) state_d = ST_DMC;
        else if (dma_req_in) state_d = ST_DMA;
        else                 state_d = ST_REL;
      end
      ST_DBG: begin
        if (!dbg_req_in) state_d = ST_REL;
      end
      ST_DMC: begin
        state_d = ST_DMCW;
        wait_d  = 8'd1;
        capture = (DMC_LAT <= 1);
      end
      ST_DMCW: begin
        if (dmcw_done) begin
          state_d = ST_REL;
          capture = (DMC_LAT > 1);
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DMA: begin
        if (!dma_req_in)                                  state_d = ST_REL;
        else if ((dbg_req_in || dmc_req_in) && !dma_lock_in) state_d = ST_HALT;
      end
      ST_REL: begin
        state_d = any_req ? ST_HALT : ST_CPU;
      end
      default: state_d = ST_CPU;
    endcase
  end

  // Registered status outputs follow the next owner so they change on the owner edge.
  always_comb begin
    cpu_ready_d = (state_d == ST_CPU);
    dbg_gnt_d   = (state_d == ST_DBG);
    dmc_gnt_d   = (state_d == ST_DMC) || (state_d == ST_DMCW);
    dma_gnt_d   = (state_d == ST_DMA);
    dmc_ack_d   = capture;
    dmc_d_d     = capture ? cpumc_din_in : dmc_d_q;
  end

  // Owner state and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_CPU;
      wait_q      <= '0;
      cpu_ready_q <= 1'b1;
      dbg_gnt_q   <= 1'b0;
      dmc_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      dmc_ack_q   <= 1'b0;
      dmc_d_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_gnt_q   <= dbg_gnt_d;
      dmc_gnt_q   <= dmc_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      dmc_ack_q   <= dmc_ack_d;
      dmc_d_q     <= dmc_d_d;
    end
  end

  // Bus select on the registered owner; parked cycles read PARK_ADDR.
  always_comb begin
    cpumc_a_out    = PARK_ADDR;
    cpumc_r_nw_out = 1'b1;
    cpumc_d_out    = '0;
    unique case (state_q)
      ST_CPU: begin
        cpumc_a_out    = cpu_a_in;
        cpumc_r_nw_out = cpu_r_nw_in;
        cpumc_d_out    = cpu_d_in;
      end
      ST_DBG: begin
        cpumc_a_out    = dbg_a_in;
        cpumc_r_nw_out = dbg_r_nw_in;
        cpumc_d_out    = dbg_d_in;
      end
      ST_DMA: begin
        cpumc_a_out    = dma_a_in;
        cpumc_r_nw_out = dma_r_nw_in;
        cpumc_d_out    = dma_d_in;
      end
      ST_DMC, ST_DMCW: begin
        cpumc_a_out = dmc_a_in;
      end
      default: begin
        cpumc_a_out = PARK_ADDR;
      end
    endcase
  end

  assign cpu_ready_out = cpu_ready_q;
  assign dbg_gnt_out   = dbg_gnt_q;
  assign dmc_gnt_out   = dmc_gnt_q;
  assign dma_gnt_out   = dma_gnt_q;
  assign dmc_ack_out   = dmc_ack_q;
  assign dmc_d_out     = dmc_d_q;

`ifdef CPUMC_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled CPU cycles; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr_in)                          stall_cnt_d = '0;
    else if (!cpu_ready_q && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cpumc_arb.sv
// Self-checking bench for cpumc_arb: owner model + directed and random stimulus.
module tb_cpumc_arb;
  localparam logic [15:0] PARK = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic        cpu_r_nw;
  logic [7:0]  cpu_d;
  logic        cpu_ready_out;
  logic        dbg_req, dbg_r_nw;
  logic [15:0] dbg_a;
  logic [7:0]  dbg_d;
  logic        dbg_gnt_out;
  logic        dmc_req;
  logic [15:0] dmc_a;
  logic        dmc_gnt_out, dmc_ack_out;
  logic [7:0]  dmc_d_out;
  logic        dma_req, dma_lock, dma_r_nw;
  logic [15:0] dma_a;
  logic [7:0]  dma_d;
  logic        dma_gnt_out;
  logic [7:0]  cpumc_din;
  logic [15:0] cpumc_a_out;
  logic        cpumc_r_nw_out;
  logic [7:0]  cpumc_d_out;
`ifdef CPUMC_ARB_STATS_EN
  logic        stall_clr;
  logic [15:0] stall_cnt_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpumc_arb #(.PARK_ADDR(PARK), .DMC_LAT(1)) dut (
    .clk_in(clk), .rst_in(rst),
    .cpu_a_in(cpu_a), .cpu_r_nw_in(cpu_r_nw), .cpu_d_in(cpu_d),
    .cpu_ready_out(cpu_ready_out),
    .dbg_req_in(dbg_req), .dbg_a_in(dbg_a), .dbg_r_nw_in(dbg_r_nw), .dbg_d_in(dbg_d),
    .dbg_gnt_out(dbg_gnt_out),
    .dmc_req_in(dmc_req), .dmc_a_in(dmc_a), .dmc_gnt_out(dmc_gnt_out),
    .dmc_ack_out(dmc_ack_out), .dmc_d_out(dmc_d_out),
    .dma_req_in(dma_req), .dma_lock_in(dma_lock), .dma_a_in(dma_a),
    .dma_r_nw_in(dma_r_nw), .dma_d_in(dma_d), .dma_gnt_out(dma_gnt_out),
    .cpumc_din_in(cpumc_din), .cpumc_a_out(cpumc_a_out),
    .cpumc_r_nw_out(cpumc_r_nw_out), .cpumc_d_out(cpumc_d_out)
`ifdef CPUMC_ARB_STATS_EN
    , .stall_clr_in(stall_clr), .stall_cnt_out(stall_cnt_out)
`endif
  );

  // Memory image: one pinned byte, everything else derived from the address.
  function automatic logic [7:0] ram_val(input logic [15:0] a);
    if (a == 16'hC000) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign cpumc_din = cpumc_r_nw_out ? ram_val(cpumc_a_out) : 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 = parked turnaround), whether the
  // parked cycle is an arbitration point, and DMC fetch progress.
  int          m_own;
  bit          m_arb;
  int          m_age;
  bit          m_ack;
  logic [7:0]  m_dmc_d;
  int unsigned m_stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = 0; m_arb = 0; m_age = 0; m_ack = 0; m_dmc_d = 8'h00; m_stall = 0;
    end else begin
      bit any;
      any   = dbg_req | dmc_req | dma_req;
      m_ack = 0;
`ifdef CPUMC_ARB_STATS_EN
      if (stall_clr) m_stall = 0;
      else if (m_own != 0 && m_stall < 65535) m_stall++;
`endif
      case (m_own)
        0: if (any && cpu_r_nw) begin m_own = -1; m_arb = 1; end
        1: if (!dbg_req) begin m_own = -1; m_arb = 0; end
        2: begin
          if (m_age == 0) begin
            m_dmc_d = ram_val(dmc_a);
            m_ack   = 1;
            m_age   = 1;
          end else begin
            m_own = -1; m_arb = 0;
          end
        end
        3: begin
          if (!dma_req) begin m_own = -1; m_arb = 0; end
          else if ((dbg_req || dmc_req) && !dma_lock) begin m_own = -1; m_arb = 1; end
        end
        default: begin
          if (m_arb) begin
            if (dbg_req)      m_own = 1;
            else if (dmc_req) begin m_own = 2; m_age = 0; end
            else if (dma_req) m_own = 3;
            else              m_arb = 0;
          end else if (any) begin
            m_arb = 1;
          end else begin
            m_own = 0;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      logic [15:0] ea; logic er; logic [7:0] ed;
      case (m_own)
        0:       begin ea = cpu_a; er = cpu_r_nw; ed = cpu_d; end
        1:       begin ea = dbg_a; er = dbg_r_nw; ed = dbg_d; end
        2:       begin ea = dmc_a; er = 1'b1;     ed = 8'h00; end
        3:       begin ea = dma_a; er = dma_r_nw; ed = dma_d; end
        default: begin ea = PARK;  er = 1'b1;     ed = 8'h00; end
      endcase
      chk("ready",   32'(cpu_ready_out), 32'(m_own == 0));
      chk("dbg_gnt", 32'(dbg_gnt_out),   32'(m_own == 1));
      chk("dmc_gnt", 32'(dmc_gnt_out),   32'(m_own == 2));
      chk("dma_gnt", 32'(dma_gnt_out),   32'(m_own == 3));
      chk("dmc_ack", 32'(dmc_ack_out),   32'(m_ack));
      chk("dmc_d",   32'(dmc_d_out),     32'(m_dmc_d));
      chk("bus_a",   32'(cpumc_a_out),   32'(ea));
      chk("bus_rnw", 32'(cpumc_r_nw_out), 32'(er));
      chk("bus_d",   32'(cpumc_d_out),   32'(ed));
`ifdef CPUMC_ARB_STATS_EN
      chk("stall_cnt", 32'(stall_cnt_out), m_stall);
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, acks, first, dbg_cyc, cyc;
    bit seen_ready, done;
    logic [7:0]  got;
    logic [15:0] seq[$];

    rst = 1'b1;
    cpu_a = 16'h0010; cpu_r_nw = 1'b1; cpu_d = 8'h00;
    dbg_req = 0; dbg_a = 0; dbg_r_nw = 1; dbg_d = 0;
    dmc_req = 0; dmc_a = 0;
    dma_req = 0; dma_lock = 0; dma_a = 0; dma_r_nw = 1; dma_d = 0;
`ifdef CPUMC_ARB_STATS_EN
    stall_clr = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cpu_ready_out), 32'd1);
    chk("rst_gnts", {29'd0, dbg_gnt_out, dmc_gnt_out, dma_gnt_out}, 32'd0);
    chk("rst_ack", 32'(dmc_ack_out), 32'd0);
    #1 rst = 1'b0;

    // Idle CPU read then write: bus mirrors the CPU.
    @(negedge clk);
    chk("idle_rd_a", 32'(cpumc_a_out), 32'h0010);
    chk("idle_rd_rnw", 32'(cpumc_r_nw_out), 32'd1);
    #1 cpu_r_nw = 1'b0; cpu_d = 8'h5A;
    @(negedge clk);
    chk("idle_wr_rnw", 32'(cpumc_r_nw_out), 32'd0);
    chk("idle_wr_d", 32'(cpumc_d_out), 32'h5A);
    chk("idle_ready", 32'(cpu_ready_out), 32'd1);

    // DMC fetch during a CPU read.
    #1 cpu_r_nw = 1'b1; cpu_a = 16'h0020; dmc_req = 1'b1; dmc_a = 16'hC000;
    low = 0; acks = 0; got = 8'h00; seq.delete(); done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_ready_out) begin low++; seq.push_back(cpumc_a_out); end
      if (dmc_ack_out) begin acks++; got = dmc_d_out; end
      if (cpu_ready_out && low > 0) begin done = 1; break; end
      #1 if (dmc_gnt_out) dmc_req = 1'b0;
    end
    chk("dmc_done", 32'(done), 32'd1);
    chk("dmc_stall_len", 32'(low), 32'd4);
    chk("dmc_acks", 32'(acks), 32'd1);
    chk("dmc_byte", 32'(got), 32'h3C);
    if (seq.size() == 4) begin
      chk("dmc_seq0", 32'(seq[0]), 32'(PARK));
      chk("dmc_seq1", 32'(seq[1]), 32'hC000);
      chk("dmc_seq2", 32'(seq[2]), 32'hC000);
      chk("dmc_seq3", 32'(seq[3]), 32'(PARK));
    end else begin
      chk("dmc_seq_len", 32'(seq.size()), 32'd4);
    end

    // DMA request coincides with a CPU write; later preempted by DMC under lock.
    #1 cpu_a = 16'h0200; cpu_r_nw = 1'b0; cpu_d = 8'h5A;
    dma_req = 1'b1; dma_a = 16'h0300; dma_r_nw = 1'b1;
    @(negedge clk);
    chk("dmaw_ready", 32'(cpu_ready_out), 32'd1);
    chk("dmaw_a", 32'(cpumc_a_out), 32'h0200);
    chk("dmaw_rnw", 32'(cpumc_r_nw_out), 32'd0);
    #1 cpu_r_nw = 1'b1; cpu_a = 16'h0400;
    @(negedge clk);
    chk("dma_halt_ready", 32'(cpu_ready_out), 32'd0);
    chk("dma_halt_a", 32'(cpumc_a_out), 32'(PARK));
    @(negedge clk);
    chk("dma_gnt", 32'(dma_gnt_out), 32'd1);
    chk("dma_a", 32'(cpumc_a_out), 32'h0300);
    #1 dmc_req = 1'b1; dmc_a = 16'hC001; dma_lock = 1'b1;
    @(negedge clk);
    chk("lock_hold1", 32'(dma_gnt_out), 32'd1);
    @(negedge clk);
    chk("lock_hold2", 32'(dma_gnt_out), 32'd1);
    #1 dma_lock = 1'b0;
    @(negedge clk);
    chk("preempt_gnt", 32'(dma_gnt_out), 32'd0);
    chk("preempt_a", 32'(cpumc_a_out), 32'(PARK));
    cyc = 0; seen_ready = 0; acks = 0; done = 0;
    for (int i = 0; i < 20; i++) begin
      #1 if (dmc_gnt_out) dmc_req = 1'b0;
      @(negedge clk);
      cyc++;
      if (cpu_ready_out) seen_ready = 1;
      if (dmc_ack_out) acks++;
      if (dma_gnt_out) begin done = 1; break; end
    end
    chk("regrant_done", 32'(done), 32'd1);
    chk("regrant_cycles", 32'(cyc), 32'd5);
    chk("regrant_no_cpu", 32'(seen_ready), 32'd0);
    chk("regrant_acks", 32'(acks), 32'd1);
    #1 dma_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("dma_end_ready", 32'(cpu_ready_out), 32'd1);

    // Debugger and DMC together: debugger first, DMC right after.
    #1 dbg_req = 1'b1; dbg_a = 16'h1234; dbg_r_nw = 1'b0; dbg_d = 8'h77;
    dmc_req = 1'b1; dmc_a = 16'hC000;
    first = 0; dbg_cyc = 0; acks = 0; low = 0; done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!cpu_ready_out) low++;
      if (dbg_gnt_out && first == 0) begin
        first = 1;
        chk("dbg_bus_a", 32'(cpumc_a_out), 32'h1234);
        chk("dbg_bus_d", 32'(cpumc_d_out), 32'h77);
        chk("dbg_bus_rnw", 32'(cpumc_r_nw_out), 32'd0);
      end
      if (dmc_gnt_out && first == 0) first = 2;
      if (dbg_gnt_out) dbg_cyc++;
      if (dmc_ack_out) acks++;
      if (cpu_ready_out && low > 0) begin done = 1; break; end
      #1;
      if (dbg_cyc >= 3) dbg_req = 1'b0;
      if (dmc_gnt_out) dmc_req = 1'b0;
    end
    chk("dd_done", 32'(done), 32'd1);
    chk("dd_first_dbg", 32'(first), 32'd1);
    chk("dd_dmc_served", 32'(acks), 32'd1);
    // HALT, 3 x DBG, REL, HALT, DMC, DMCW, REL
    chk("dd_stall_len", 32'(low), 32'd9);

    // Reset pulsed while the DMC fetch sits in DMCW.
    #1 dmc_req = 1'b1; dmc_a = 16'hC000;
    done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmc_ack_out) begin done = 1; break; end
      #1 if (dmc_gnt_out) dmc_req = 1'b0;
    end
    chk("rst_mid_reached", 32'(done), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(cpu_ready_out), 32'd1);
    chk("rst_mid_gnts", {29'd0, dbg_gnt_out, dmc_gnt_out, dma_gnt_out}, 32'd0);
    chk("rst_mid_ack", 32'(dmc_ack_out), 32'd0);
    chk("rst_mid_a", 32'(cpumc_a_out), 32'(cpu_a));
    @(negedge clk);
    #1 rst = 1'b0; dmc_req = 1'b0;

    // Randomised traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      cpu_a    = 16'($urandom);
      cpu_r_nw = ($urandom_range(3) != 0);
      cpu_d    = 8'($urandom);
      dbg_a    = 16'($urandom); dbg_r_nw = 1'($urandom); dbg_d = 8'($urandom);
      dma_a    = 16'($urandom); dma_r_nw = 1'($urandom); dma_d = 8'($urandom);
      if ($urandom_range(24) == 0) dmc_a = 16'($urandom);
      if ($urandom_range(15) == 0) dbg_req = ~dbg_req;
      if (dmc_gnt_out) dmc_req = 1'b0;
      else if ($urandom_range(19) == 0) dmc_req = 1'b1;
      if ($urandom_range(11) == 0) dma_req = ~dma_req;
      dma_lock = ($urandom_range(3) == 0);
`ifdef CPUMC_ARB_STATS_EN
      stall_clr = ($urandom_range(99) == 0);
`endif
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpumc_arb.md
Name: cpumc_arb

Overview:
- Sequential arbiter for the shared CPU memory bus into cpumc, the PPU register port and the joypad.
- Requesters, in priority order: debugger (dbg), APU DMC sample fetch (dmc), sprite DMA (dma), CPU.
- Stalls the CPU through its ready input.
- Hands the bus over only at safe points, with a parked, side-effect-free turnaround cycle.
- Sits between the cpu, dbg, sprdma and apu blocks and the cpumc bus.

Parameters:
- PARK_ADDR, 16'h0000: address driven, as a read, during turnaround cycles (RAM, no side effects).
- DMC_LAT, 1: cycles from DMC address drive to valid cpumc read data.

Ports:
- clk_in  input  1  system clock (50MHz)
- rst_in  input  1  reset, asynchronous, active-high
- cpu_a_in  input  16  CPU address
- cpu_r_nw_in  input  1  CPU R/!W
- cpu_d_in  input  8  CPU write data
- cpu_ready_out  output  1  CPU ready; low stalls the CPU
- dbg_req_in  input  1  debugger bus request (level)
- dbg_a_in  input  16  debugger address
- dbg_r_nw_in  input  1  debugger R/!W
- dbg_d_in  input  8  debugger write data
- dbg_gnt_out  output  1  debugger owns the bus
- dmc_req_in  input  1  DMC single-byte read request (level)
- dmc_a_in  input  16  DMC read address
- dmc_gnt_out  output  1  DMC address is on the bus
- dmc_ack_out  output  1  one-cycle pulse: dmc_d_out valid
- dmc_d_out  output  8  captured DMC read byte
- dma_req_in  input  1  sprite DMA request (level)
- dma_lock_in  input  1  DMA read/write pair in flight; blocks preemption
- dma_a_in  input  16  DMA address
- dma_r_nw_in  input  1  DMA R/!W
- dma_d_in  input  8  DMA write data
- dma_gnt_out  output  1  DMA owns the bus
- cpumc_din_in  input  8  ORed read data returned from the bus
- cpumc_a_out  output  16  bus address
- cpumc_r_nw_out  output  1  bus R/!W
- cpumc_d_out  output  8  bus write data

Behaviour:
- States: CPU, HALT, DBG, DMC, DMCW, DMA, REL. Single registered owner state.
- Bus outputs are a combinational select on the registered state:
  - CPU: cpu_* inputs.
  - DBG / DMA: that requester's inputs.
  - DMC and DMCW: dmc_a_in, r_nw=1, d=0.
  - HALT and REL: PARK_ADDR, r_nw=1, d=0.
- Reset (asynchronous): state=CPU; cpu_ready_out=1; all gnt=0; dmc_ack_out=0; dmc_d_out=0.
- Reset asserted mid-operation aborts any transfer immediately with no completion ack; the requester re-requests.
- CPU state:
  - Any request with cpu_r_nw_in=1 -> HALT; cpu_ready_out goes low on the same edge.
  - While cpu_r_nw_in=0 the state stays CPU, so a CPU write always completes.
- HALT (exactly 1 cycle): grant the highest-priority active request, dbg > dmc > dma. The matching gnt is registered high on the exit edge.
  - If the request was withdrawn, go to REL.
- DBG: hold while dbg_req_in=1, then REL.
- DMC: 1 cycle with the address on the bus, then DMCW.
- DMCW: DMC_LAT-1 extra cycles. On exit, capture cpumc_din_in into dmc_d_out, pulse dmc_ack_out for 1 cycle, then REL.
  - With DMC_LAT=1 the capture happens on the DMC->DMCW edge and DMCW lasts 1 cycle.
- DMA: hold while dma_req_in=1.
  - If dbg_req_in or dmc_req_in rises and dma_lock_in=0: drop dma_gnt_out, go to HALT, and re-arbitrate.
  - The DMA must freeze while its grant is low and resume when regranted.
  - When dma_lock_in=1, preemption waits until lock falls.
- REL (1 cycle):
  - If any request is pending, go to HALT; cpu_ready_out stays low.
  - Otherwise go to CPU; cpu_ready_out goes high on that edge.
- Simultaneous requests resolve in HALT by priority. Lower-priority requests are held and served next, without passing through CPU.
- Minimum CPU stall for one DMC fetch: 4 cycles (HALT, DMC, DMCW, REL).
- At most one gnt is high at any time. cpu_ready_out=1 if and only if state=CPU.

Optional Feature:
- Macro CPUMC_ARB_STATS_EN.
- Enabled:
  - Adds output stall_cnt_out[15:0]: counts cycles with cpu_ready_out=0, saturating at 16'hFFFF.
  - Adds input stall_clr_in: synchronous clear, which wins over the increment.
  - Counter resets to 0.
- Disabled: neither port exists and no counter logic is built.

Test Plan:
- Idle, CPU reads 16'h0010 then writes 8'h5A -> bus mirrors CPU every cycle; cpu_ready_out stays 1.
- dmc_req_in while CPU reads (RAM[16'hC000]=8'h3C, dmc_a_in=16'hC000):
  - Response sequence: HALT (addr=PARK_ADDR), DMC (addr=C000), DMCW, REL.
  - dmc_ack_out pulses once with dmc_d_out=8'h3C.
  - cpu_ready_out is low for exactly 4 cycles.
- dma_req_in coincides with a CPU write (cpu_r_nw_in=0) -> write to 16'h0200 completes first; HALT follows on the next CPU read cycle.
- DMA running, dmc_req_in rises with dma_lock_in=1 for 2 cycles -> dma_gnt_out stays high 2 more cycles, then HALT, DMC service, HALT, DMA regranted; cpu_ready_out never rises.
- dbg_req_in and dmc_req_in asserted together -> dbg granted first; dmc served after dbg releases, without a CPU cycle between.
- rst_in pulsed mid-DMCW -> immediately state=CPU, all gnt=0, dmc_ack_out=0, cpu_ready_out=1.
